// File: rtl/hit_responder.sv
// Ghost-hit responder: fixed-priority ack of four held hit requests, BCD health, cooldown and game-over.
// Cooldown (INVULN state, tick counter) is built only when HIT_RESPONDER_INVULN_EN is defined.
module hit_responder #(
  parameter int START_HP     = 3,
  parameter int INVULN_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] hit_req,
  input  logic       restart,
  output logic [3:0] hit_ack,
  output logic [3:0] hp_dig,
  output logic       damage,
  output logic       invuln,
  output logic       game_over
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OVER = 2'd2;
`ifdef HIT_RESPONDER_INVULN_EN
  localparam logic [1:0] INVULN = 2'd1;
`endif
  localparam logic [3:0] HP_INIT   = 4'(START_HP);
  localparam logic [7:0] COOL_LOAD = 8'(INVULN_TICKS);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] hp_nxt;
  logic [3:0] ack_nxt;
  logic [3:0] eligible;
  logic [3:0] grant;
  logic       granted;
  logic       damage_nxt;
  logic       over_nxt;

`ifdef HIT_RESPONDER_INVULN_EN
  logic [7:0] cool_cnt;
  logic [7:0] cool_nxt;
  logic       invuln_q;
  logic       invuln_nxt;
`else
  logic       unused_cfg;
  assign unused_cfg = ^{COOL_LOAD, tick};
`endif

  // Last cycle's ack masks its own bit so a request still held during the ack is not re-granted.
  assign eligible = hit_req & ~hit_ack;

  always_comb begin
    grant = 4'b0000;
    if (eligible[0])      grant = 4'b0001;
    else if (eligible[1]) grant = 4'b0010;
    else if (eligible[2]) grant = 4'b0100;
    else if (eligible[3]) grant = 4'b1000;
  end

  assign granted = |grant;

  always_comb begin
    state_nxt  = state;
    hp_nxt     = hp_dig;
    ack_nxt    = grant;
    damage_nxt = 1'b0;
    over_nxt   = game_over;
`ifdef HIT_RESPONDER_INVULN_EN
    cool_nxt   = cool_cnt;
    invuln_nxt = invuln_q;
`endif
    case (state)
      IDLE: begin
        if (granted) begin
          damage_nxt = 1'b1;
          if (hp_dig > 4'd1) begin
            hp_nxt = hp_dig - 4'd1;
`ifdef HIT_RESPONDER_INVULN_EN
            state_nxt  = INVULN;
            cool_nxt   = COOL_LOAD;
            invuln_nxt = 1'b1;
`endif
          end else begin
            hp_nxt    = 4'd0;
            over_nxt  = 1'b1;
            state_nxt = OVER;
          end
        end
      end
`ifdef HIT_RESPONDER_INVULN_EN
      // Grants here are still acked but harmless; only tick strobes drain the counter.
      INVULN: begin
        if (tick) begin
          if (cool_cnt <= 8'd1) begin
            cool_nxt   = 8'd0;
            invuln_nxt = 1'b0;
            state_nxt  = IDLE;
          end else begin
            cool_nxt = cool_cnt - 8'd1;
          end
        end
      end
`endif
      OVER: begin
        hp_nxt = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (restart) begin
      state_nxt  = IDLE;
      hp_nxt     = HP_INIT;
      ack_nxt    = 4'b0000;
      damage_nxt = 1'b0;
      over_nxt   = 1'b0;
`ifdef HIT_RESPONDER_INVULN_EN
      cool_nxt   = 8'd0;
      invuln_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hp_dig    <= HP_INIT;
      hit_ack   <= 4'b0000;
      damage    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      hp_dig    <= hp_nxt;
      hit_ack   <= ack_nxt;
      damage    <= damage_nxt;
      game_over <= over_nxt;
    end
  end

`ifdef HIT_RESPONDER_INVULN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cool_cnt <= 8'd0;
      invuln_q <= 1'b0;
    end else begin
      cool_cnt <= cool_nxt;
      invuln_q <= invuln_nxt;
    end
  end

  assign invuln = invuln_q;
`else
  assign invuln = 1'b0;
`endif

endmodule

// File: tb/tb_hit_responder.sv
// Randomized bench for hit_responder against a cycle-level behavioural model of the hit rules.
module tb_hit_responder;

  localparam int START_HP = 3;
  localparam int TICKS    = 3;
`ifdef HIT_RESPONDER_INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       tick;
  logic       restart;
  logic [3:0] hit_req;
  logic [3:0] hit_ack;
  logic [3:0] hp_dig;
  logic       damage;
  logic       invuln;
  logic       game_over;

  hit_responder #(.START_HP(START_HP), .INVULN_TICKS(TICKS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .hit_req(hit_req), .restart(restart),
    .hit_ack(hit_ack), .hp_dig(hp_dig), .damage(damage), .invuln(invuln),
    .game_over(game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_tests;
  int         n_fail;
  int         m_hp;
  int         m_cool;
  bit         m_over;
  bit         m_dmg;
  logic [3:0] m_ack;
  logic [3:0] drop_pending;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hp         = START_HP;
    m_cool       = 0;
    m_over       = 1'b0;
    m_dmg        = 1'b0;
    m_ack        = 4'b0000;
    drop_pending = 4'b0000;
  endtask

  // Lowest-numbered request not acked last cycle wins; damage only outside cooldown and game-over.
  task automatic model_edge();
    logic [3:0] g;
    bit         found;
    g     = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && hit_req[i] && !m_ack[i]) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    if (restart) begin
      m_hp   = START_HP;
      m_cool = 0;
      m_over = 1'b0;
      m_ack  = 4'b0000;
      m_dmg  = 1'b0;
    end else begin
      m_ack = g;
      m_dmg = 1'b0;
      if (m_over) begin
        m_hp = 0;
      end else if (m_cool > 0) begin
        if (tick) m_cool = m_cool - 1;
      end else if (found) begin
        m_dmg = 1'b1;
        if (m_hp > 1) begin
          m_hp = m_hp - 1;
          if (INV_EN) m_cool = TICKS;
        end else begin
          m_hp   = 0;
          m_over = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ack", hit_ack, m_ack);
    chk("hp", hp_dig, m_hp);
    chk("damage", damage, m_dmg);
    chk("invuln", invuln, m_cool > 0);
    chk("game_over", game_over, m_over);
  endtask

  // Initiator holds each request through its ack cycle, then drops it.
  task automatic cyc(input logic [3:0] raise, input logic t, input logic rs);
    hit_req = hit_req | raise;
    tick    = t;
    restart = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    hit_req      = hit_req & ~drop_pending;
    drop_pending = m_ack;
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("arst_ack", hit_ack, 4'b0000);
    chk("arst_hp", hp_dig, START_HP);
    chk("arst_damage", damage, 1'b0);
    chk("arst_invuln", invuln, 1'b0);
    chk("arst_game_over", game_over, 1'b0);
    model_reset();
    #2 rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    tick    = 1'b0;
    restart = 1'b0;
    hit_req = 4'b0000;
    model_reset();
    #12;
    chk("rst_ack", hit_ack, 4'b0000);
    chk("rst_hp", hp_dig, START_HP);
    chk("rst_damage", damage, 1'b0);
    chk("rst_invuln", invuln, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    #1 rst = 1'b1;

    // First grant straight after release, then the held bit must stay masked.
    cyc(4'b0001, 1'b0, 1'b0);
    chk("first_ack", hit_ack, 4'b0001);
    chk("first_hp", hp_dig, START_HP - 1);
    chk("first_damage", damage, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("masked_ack", hit_ack, 4'b0000);
    chk("masked_hp", hp_dig, START_HP - 1);

    cyc(4'b1010, 1'b0, 1'b0);
    chk("prio_ack", hit_ack, 4'b0010);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("prio_ack2", hit_ack, 4'b1000);
    cyc(4'b0000, 1'b0, 1'b0);

    // Cooldown boundary: request coincident with the last tick, then one after it.
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) cyc(4'b0001, 1'b1, 1'b0);
    chk("over_go", game_over, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("over_hp", hp_dig, 4'd0);

    cyc(4'b0001, 1'b0, 1'b1);
    chk("restart_ack", hit_ack, 4'b0000);
    chk("restart_hp", hp_dig, START_HP);
    chk("restart_go", game_over, 1'b0);
    chk("restart_invuln", invuln, 1'b0);

    for (int i = 0; i < 4; i++) cyc(4'b0011, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    async_reset();
    cyc(4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
          $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_responder.md
HIT_RESPONDER -- requirements
Module: hit_responder

Interface
REQ-001 The module SHALL have parameter START_HP, default 3, giving the health loaded at reset and restart (legal range 1..9).
REQ-002 The module SHALL have parameter INVULN_TICKS, default 120, giving the post-hit cooldown in tick strobes (legal range 1..255).
REQ-003 The module SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port tick  input  1  one-cycle frame strobe (60 Hz rate) used by the cooldown counter.
REQ-006 The module SHALL have port hit_req  input  4  per-ghost hit request, level, held by the initiator until acknowledged.
REQ-007 The module SHALL have port restart  input  1  synchronous new-game request.
REQ-008 The module SHALL have port hit_ack  output  4  registered one-cycle acknowledge, at most one bit set.
REQ-009 The module SHALL have port hp_dig  output  4  current health as one BCD digit, for the seven-segment driver.
REQ-010 The module SHALL have port damage  output  1  registered one-cycle pulse per health decrement.
REQ-011 The module SHALL have port invuln  output  1  high while in cooldown.
REQ-012 The module SHALL have port game_over  output  1  high while health is 0.

Function
REQ-013 The FSM SHALL have states IDLE, INVULN and OVER, and all outputs SHALL be registered.
REQ-014 Arbitration SHALL be fixed priority: hit_req[0] is highest and hit_req[3] is lowest. Exactly one request SHALL be granted per cycle, and others remain pending.
REQ-015 The acknowledge SHALL appear one cycle after the edge at which the request is sampled: request sampled at edge N gives hit_ack bit high for the cycle after edge N, then low.
REQ-016 A request bit whose ack was high in the previous cycle SHALL be masked for one cycle, so a held request is never counted twice.
REQ-017 IDLE behaviour with a granted request and hp_dig>1: decrement hp_dig, pulse damage, load the cooldown counter with INVULN_TICKS, and go to INVULN.
REQ-018 IDLE behaviour with a granted request and hp_dig==1: set hp_dig to 0, pulse damage, set game_over, and go to OVER.
REQ-019 In INVULN, requests SHALL still be granted and acked with the same rules, with no damage and hp_dig unchanged.
REQ-020 INVULN exit: the counter SHALL decrement only on cycles where tick=1. The edge at which it reaches 0 SHALL move the FSM to IDLE, with invuln low from the next cycle.
REQ-021 In OVER, requests SHALL be acked and dropped, and hp_dig SHALL stay at 0 (no underflow). Only restart or rst leaves OVER.
REQ-022 restart=1 in any state SHALL give, at the next edge: hp_dig=START_HP, game_over=0, invuln=0, counter=0, state IDLE, and no ack or damage that cycle. restart takes priority over a simultaneous hit.
REQ-023 A tick coinciding with a grant SHALL NOT decrement the newly loaded counter.

Reset
REQ-024 While rst=0, asynchronously: state=IDLE, hp_dig=START_HP, hit_ack=0, damage=0, invuln=0, game_over=0, counter=0, ack mask=0.
REQ-025 Release of rst SHALL be taken synchronously. The first grant SHALL be possible at the first edge after release.
REQ-026 rst asserted mid-cooldown or mid-handshake SHALL discard all pending state. Requests still held after release are treated as new.

Configuration
REQ-027 Macro HIT_RESPONDER_INVULN_EN defined: the INVULN state, the counter and INVULN_TICKS behave as in REQ-017 to REQ-023.
REQ-028 Macro HIT_RESPONDER_INVULN_EN undefined: no INVULN state or counter is built, and invuln is tied to 0. A non-fatal hit SHALL return the FSM to IDLE, so every granted request in IDLE decrements, one per cycle.

Verification
REQ-029 Reset, then hold hit_req=0001 -> hit_ack=0001 for one cycle, damage pulse, hp_dig 3->2, invuln=1; held request masked and not re-counted.
REQ-030 hit_req=1010 simultaneous in IDLE -> hit_ack=0010 first, then 1000 on a later cycle with no damage (invuln); hp_dig=2.
REQ-031 INVULN_TICKS=3 -> invuln stays high through exactly 3 tick strobes; a hit after the 3rd tick is damaging; after 3 damaging hits, hp_dig=0, game_over=1.
REQ-032 In OVER, hit_req=0100 -> acked, hp_dig stays 0; restart=1 together with hit_req=0001 -> no ack, hp_dig=3, game_over=0.
REQ-033 rst pulsed low mid-cooldown -> all outputs return to reset values immediately, without a clock edge.
REQ-034 Build without HIT_RESPONDER_INVULN_EN, hit_req=0011 held -> two damaging acks on consecutive grants, hp_dig 3->1, invuln never high.
